// File: rtl/bcd_pkg.sv
// Shared types and widths for the BCD share arbiter.
// State encoding and data widths.
package bcd_pkg;
  localparam int BIN_W = 6;
  localparam int BCD_W = 4;
  typedef enum logic [1:0] {
    IDLE,
    CONV,
    RESP
  } state_t;
endpackage

// File: rtl/double_dabble.sv
// Combinational 6-bit binary to two-digit BCD.
// Shift-add-3 over a scratch register.
module double_dabble
  import bcd_pkg::*;
(
  input  logic [BIN_W-1:0] bin,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones
);

  localparam int SH_W = 2 * BCD_W + BIN_W;
  localparam int ONE_L = BIN_W;
  localparam int TEN_L = BIN_W + BCD_W;

  logic [SH_W-1:0] sh;

  // Adjust each digit before every shift.
  always_comb begin
    sh = {{(2 * BCD_W){1'b0}}, bin};
    for (int i = 0; i < BIN_W; i++) begin
      if (sh[ONE_L +: BCD_W] >= 4'd5)
        sh[ONE_L +: BCD_W] = sh[ONE_L +: BCD_W] + 4'd3;
      if (sh[TEN_L +: BCD_W] >= 4'd5)
        sh[TEN_L +: BCD_W] = sh[TEN_L +: BCD_W] + 4'd3;
      sh = sh << 1;
    end
    tens = sh[TEN_L +: BCD_W];
    ones = sh[ONE_L +: BCD_W];
  end

endmodule

// File: rtl/bcd_share_arbiter.sv
// Round-robin arbiter sharing one BCD converter.
// Grant in IDLE/RESP, convert in CONV, pulse in RESP.
module bcd_share_arbiter
  import bcd_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*BIN_W-1:0] i_bin,
  output logic [N_REQ-1:0]       o_gnt,
  output logic                   o_busy,
  output logic                   o_valid,
  output logic [ID_W-1:0]        o_id,
  output logic [BCD_W-1:0]       o_tens,
  output logic [BCD_W-1:0]       o_ones
);

  state_t state;
  state_t stateNext;

  logic [ID_W-1:0]  rPtr;
  logic [ID_W-1:0]  rId;
  logic [BIN_W-1:0] rBin;

  logic [ID_W-1:0]  ptrNext;
  logic [ID_W-1:0]  idNext;
  logic [BIN_W-1:0] binNext;
  logic [N_REQ-1:0] gntNext;
  logic             validNext;

  logic             winFound;
  logic [ID_W-1:0]  winIdx;
  logic [BIN_W-1:0] winBin;

  logic [BCD_W-1:0] ddTens;
  logic [BCD_W-1:0] ddOnes;

  double_dabble uDd (
    .bin  (rBin),
    .tens (ddTens),
    .ones (ddOnes)
  );

  // Pick the first requester at or after rPtr.
  always_comb begin
    int idx;
    idx      = 0;
    winFound = 1'b0;
    winIdx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = (int'(rPtr) + i) % N_REQ;
      if (i_req[idx]) begin
        winFound = 1'b1;
        winIdx   = ID_W'(idx);
      end
    end
  end

  assign winBin = i_bin[int'(winIdx) * BIN_W +: BIN_W];

  // Next state and next register values.
  always_comb begin
    stateNext = state;
    ptrNext   = rPtr;
    idNext    = rId;
    binNext   = rBin;
    gntNext   = '0;
    validNext = 1'b0;
    unique case (state)
      IDLE, RESP: begin
        if (winFound) begin
          stateNext = CONV;
          binNext   = winBin;
          idNext    = winIdx;
          gntNext   = N_REQ'(1) << winIdx;
          ptrNext   = (winIdx == ID_W'(N_REQ - 1))
                    ? '0 : winIdx + 1'b1;
        end else begin
          stateNext = IDLE;
        end
      end
      CONV: begin
        stateNext = RESP;
        validNext = 1'b1;
      end
      default: stateNext = IDLE;
    endcase
  end

  // State, capture and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      rPtr    <= '0;
      rId     <= '0;
      rBin    <= '0;
      o_gnt   <= '0;
      o_valid <= 1'b0;
      o_id    <= '0;
      o_tens  <= '0;
      o_ones  <= '0;
    end else begin
      state   <= stateNext;
      rPtr    <= ptrNext;
      rId     <= idNext;
      rBin    <= binNext;
      o_gnt   <= gntNext;
      o_valid <= validNext;
      if (validNext) begin
        o_id   <= rId;
        o_tens <= ddTens;
        o_ones <= ddOnes;
      end
    end
  end

  assign o_busy = (state == CONV) || (state == RESP);

endmodule

// File: tb/tb_bcd_share_arbiter.sv
// Directed bench for bcd_share_arbiter.
// Scoreboard of expected results popped on o_valid.
module tb_bcd_share_arbiter;

  localparam int N = 4;
  localparam int IW = 2;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic [N-1:0]  i_req;
  logic [N*6-1:0] i_bin;
  logic [N-1:0]  o_gnt;
  logic          o_busy;
  logic          o_valid;
  logic [IW-1:0] o_id;
  logic [3:0]    o_tens;
  logic [3:0]    o_ones;

  typedef struct {
    int id;
    int tens;
    int ones;
  } exp_t;

  exp_t q[$];
  int compared = 0;
  int mismatched = 0;

  bcd_share_arbiter #(.N_REQ(N)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_req   (i_req),
    .i_bin   (i_bin),
    .o_gnt   (o_gnt),
    .o_busy  (o_busy),
    .o_valid (o_valid),
    .o_id    (o_id),
    .o_tens  (o_tens),
    .o_ones  (o_ones)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(string tag, int obs, int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(int k, int v);
    exp_t e;
    e.id = k;
    e.tens = v / 10;
    e.ones = v % 10;
    q.push_back(e);
  endtask

  task automatic drive(int k, int v);
    i_bin[k*6 +: 6] = 6'(v);
    i_req[k] = 1'b1;
  endtask

  task automatic cyc();
    exp_t e;
    @(posedge i_clk);
    #1;
    if (o_valid) begin
      if (q.size() == 0) begin
        chk("spurious_valid", int'(o_valid), 0);
      end else begin
        e = q.pop_front();
        chk("id", int'(o_id), e.id);
        chk("tens", int'(o_tens), e.tens);
        chk("ones", int'(o_ones), e.ones);
      end
    end
  endtask

  task automatic serve_one(int k, int v);
    drive(k, v);
    push(k, v);
    cyc();
    chk("serve_gnt", int'(o_gnt), 1 << k);
    i_req[k] = 1'b0;
    cyc();
    chk("serve_valid", int'(o_valid), 1);
    cyc();
    chk("serve_idle", int'(o_busy), 0);
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_req = '0;
    i_bin = '0;
    #12;
    chk("rst_gnt", int'(o_gnt), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_id", int'(o_id), 0);
    chk("rst_tens", int'(o_tens), 0);
    chk("rst_ones", int'(o_ones), 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // single request, requester 2, value 45
    drive(2, 45);
    push(2, 45);
    cyc();
    chk("single_gnt", int'(o_gnt), 4);
    chk("single_busy1", int'(o_busy), 1);
    chk("single_nv", int'(o_valid), 0);
    i_req[2] = 1'b0;
    cyc();
    chk("single_valid", int'(o_valid), 1);
    chk("single_busy2", int'(o_busy), 1);
    chk("single_gnt0", int'(o_gnt), 0);
    cyc();
    chk("single_busy3", int'(o_busy), 0);
    chk("single_v0", int'(o_valid), 0);

    // full sweep on requester 0
    for (int v = 0; v < 64; v++) serve_one(0, v);

    // pointer rotation: serve 3, then 0 and 3 together
    serve_one(3, 43);
    drive(0, 5);
    drive(3, 60);
    push(0, 5);
    push(3, 60);
    cyc();
    chk("rot_first", int'(o_gnt), 1);
    i_req[0] = 1'b0;
    cyc();
    chk("rot_v0", int'(o_valid), 1);
    cyc();
    chk("rot_second", int'(o_gnt), 8);
    i_req[3] = 1'b0;
    cyc();
    chk("rot_v3", int'(o_valid), 1);
    cyc();
    chk("rot_idle", int'(o_busy), 0);

    // continuous round robin
    for (int k = 0; k < N; k++) drive(k, 10 + 11 * k);
    for (int j = 0; j < 5; j++) push(j % N, 10 + 11 * (j % N));
    for (int j = 0; j < 5; j++) begin
      cyc();
      chk("rr_gnt", int'(o_gnt), 1 << (j % N));
      if (j == 4) i_req = '0;
      cyc();
      chk("rr_valid", int'(o_valid), 1);
      chk("rr_gap", int'(o_gnt), 0);
    end
    cyc();
    chk("rr_idle", int'(o_busy), 0);

    // withdrawn request during CONV
    drive(0, 7);
    push(0, 7);
    cyc();
    chk("wd_gnt0", int'(o_gnt), 1);
    i_req[0] = 1'b0;
    drive(1, 30);
    cyc();
    chk("wd_valid", int'(o_valid), 1);
    chk("wd_nogntA", int'(o_gnt), 0);
    i_req[1] = 1'b0;
    cyc();
    chk("wd_nogntB", int'(o_gnt), 0);
    chk("wd_idle", int'(o_busy), 0);
    cyc();
    chk("wd_nogntC", int'(o_gnt), 0);

    // reset during CONV
    drive(2, 50);
    cyc();
    chk("mr_gnt", int'(o_gnt), 4);
    i_req[2] = 1'b0;
    i_rst_n = 1'b0;
    #1;
    chk("mr_gnt0", int'(o_gnt), 0);
    chk("mr_busy", int'(o_busy), 0);
    chk("mr_valid", int'(o_valid), 0);
    chk("mr_id", int'(o_id), 0);
    chk("mr_tens", int'(o_tens), 0);
    chk("mr_ones", int'(o_ones), 0);
    cyc();
    chk("mr_nv1", int'(o_valid), 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    cyc();
    chk("mr_nv2", int'(o_valid), 0);
    cyc();
    chk("mr_nv3", int'(o_valid), 0);
    serve_one(1, 19);

    chk("sb_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bcd_share_arbiter.md
# bcd_share_arbiter

Round-robin scheduler that shares one combinational 6-bit binary-to-BCD converter (`double_dabble`) between `N_REQ` requesters, such as score and timer fields driving multiplexed 7-segment digits. Each requester presents a 6-bit value and a level request. The arbiter grants one requester at a time, captures its value, and sequences the converter. It then returns registered tens/ones digits, tagged with the requester ID, together with a one-cycle valid pulse.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default `$clog2(N_REQ)`: width of the requester ID.
- `i_clk`  in  1: the single clock; all state changes on its rising edge.
- `i_rst_n`  in  1: asynchronous, active-low reset.
- `i_req`  in  `N_REQ`: level request, one bit per requester.
- `i_bin`  in  `N_REQ*6`: packed values; requester k uses bits `[6k+5:6k]`.
- `o_gnt`  out  `N_REQ`: one-hot grant pulse, high for one cycle when requester k's value is captured.
- `o_busy`  out  1: high while a conversion is in flight (states CONV and RESP).
- `o_valid`  out  1: one-cycle pulse; `o_tens`, `o_ones` and `o_id` are valid in that cycle.
- `o_id`  out  `ID_W`: requester whose result is on the outputs.
- `o_tens`  out  4: BCD tens digit, 0..6.
- `o_ones`  out  4: BCD ones digit, 0..9.

## Operation
- FSM states: IDLE, CONV, RESP. Reset state is IDLE.
- Arbitration takes place in IDLE and in RESP.
  - If any `i_req` bit is high, the winner is chosen round-robin starting at `r_ptr`.
  - At the clock edge the arbiter registers the winner's `i_bin` slice into `r_bin` and its index into `r_id`, sets `o_gnt` to the winner's one-hot code, and moves to CONV.
  - After a grant to requester k, `r_ptr` becomes (k+1) mod `N_REQ`.
  - If no request is present, IDLE stays in IDLE and RESP goes to IDLE.
- CONV: `r_bin` drives the `double_dabble` input. At the edge the arbiter registers `o_tens`, `o_ones` and `o_id` (taken from `r_id`), raises `o_valid` and moves to RESP.
- RESP: `o_valid` is high for this single cycle. Arbitration runs as in IDLE.
- Output holding: `o_tens`, `o_ones` and `o_id` hold their last values until the next CONV→RESP edge. `o_gnt` and `o_valid` are zero in every other cycle.
- Requester handshake:
  - A requester holds `i_req` and a stable `i_bin` until it sees its `o_gnt` bit.
  - The captured value is the one present in the cycle before `o_gnt` is high.
  - If the requester drops `i_req` before it is granted, it is not served and no error is raised.
  - A requester that keeps `i_req` high after its grant is treated as a new request and is served again on its next round-robin turn.
- Data width: the 6-bit input yields at most 63. The `double_dabble` result has tens ≤ 6, and both digits pass through unchanged.
- Reset:
  - On assertion, including mid-conversion, all state clears immediately: state=IDLE, `r_ptr`=0, `r_bin`=0, `r_id`=0.
  - Outputs clear to `o_gnt`=0, `o_busy`=0, `o_valid`=0, `o_id`=0, `o_tens`=0, `o_ones`=0.
  - A conversion interrupted by reset produces no `o_valid`.

## Timing
- Latency: if the request is seen in IDLE in cycle t, `o_gnt` is high in t+1 (CONV) and `o_valid` is high in t+2 (RESP).
- Throughput: one conversion per 2 cycles under continuous requests, since RESP re-arbitrates directly into CONV.
- Fairness: with all requesters active, each is served once per 2·`N_REQ` cycles.
- Simultaneous events: in the RESP cycle, `o_valid` for the previous requester and arbitration for the next one happen together. The new `o_gnt` appears in the following cycle.
- Combinational path: `r_bin` → `double_dabble` → output registers. This must fit in one `i_clk` period.

## Structure
- Shared package `bcd_pkg` holds:
  - the state enum type: IDLE, CONV, RESP;
  - constants `BIN_W`=6 and `BCD_W`=4.
- One sub-module: an instance of the existing `double_dabble`. The round-robin priority logic stays inline.
- The converter is never duplicated: all requesters go through a single instance.

## Test plan
- Single request: reset, then requester 2 requests with value 45 → `o_gnt`=4'b0100 one cycle later, then `o_valid`, `o_id`=2, tens=4, ones=5. `o_busy` is high for 2 cycles.
- Extremes: values 0 and 63 → outputs 0/0 and 6/3. All values 0..63 are swept on requester 0 and checked against v/10 and v%10.
- Round-robin: all four requesters request continuously with values 10, 21, 32, 43 → grants in order 0,1,2,3,0 every 2 cycles; results 1/0, 2/1, 3/2, 4/3.
- Pointer rotation: requesters 0 and 3 both request right after requester 3 was served → requester 0 is granted first.
- Withdrawn request: requester 1 raises and drops `i_req` while requester 0 is in CONV → no `o_gnt[1]`, and the FSM returns to IDLE after RESP.
- Reset mid-operation: `i_rst_n` is asserted during CONV → all outputs go to 0 immediately and no `o_valid` follows. After release, a fresh request converts normally.
